// File: rtl/rv_mem_port_arbiter.sv
// Shares one OBI-style memory port between instruction fetch (I) and load/store (D), one transaction in flight.
// Optional build macro RV_MEM_ARB_RR_EN: round-robin on simultaneous requests (default fixed priority D > I).
module rv_mem_port_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                clk_i,
  input  logic                arstn_i,
  input  logic                instr_req_i,
  input  logic [ADDR_W-1:0]   instr_addr_i,
  input  logic                instr_flush_i,
  output logic                instr_gnt_o,
  output logic                instr_rvalid_o,
  output logic [DATA_W-1:0]   instr_rdata_o,
  input  logic                data_req_i,
  input  logic                data_we_i,
  input  logic [DATA_W/8-1:0] data_be_i,
  input  logic [ADDR_W-1:0]   data_addr_i,
  input  logic [DATA_W-1:0]   data_wdata_i,
  output logic                data_gnt_o,
  output logic                data_rvalid_o,
  output logic [DATA_W-1:0]   data_rdata_o,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [DATA_W/8-1:0] mem_be_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  input  logic                mem_gnt_i,
  input  logic                mem_rvalid_i,
  input  logic [DATA_W-1:0]   mem_rdata_i
);

  typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_RESP} state_e;
  typedef enum logic {OWN_I = 1'b0, OWN_D = 1'b1} owner_e;

  state_e                state_q, state_d;
  owner_e                owner_q, owner_d;
  logic                  drop_q, drop_d;
  logic                  mem_req_q, mem_req_d;
  logic                  mem_we_q, mem_we_d;
  logic [DATA_W/8-1:0]   mem_be_q, mem_be_d;
  logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]     mem_wdata_q, mem_wdata_d;
`ifdef RV_MEM_ARB_RR_EN
  owner_e                last_owner_q, last_owner_d;
`endif

  logic i_elig, d_elig, sel_d, launch, i_quiet;

  always_comb begin
    i_elig = instr_req_i & ~instr_flush_i;
    d_elig = data_req_i;
`ifdef RV_MEM_ARB_RR_EN
    // On a tie, hand the bus to whoever did not own it last.
    sel_d = d_elig & (~i_elig | (last_owner_q == OWN_I));
`else
    sel_d = d_elig;
`endif
    // Fetch-side handshakes are hidden once the transaction is marked stale.
    i_quiet = drop_q | instr_flush_i;

    state_d        = state_q;
    owner_d        = owner_q;
    drop_d         = drop_q;
    mem_req_d      = mem_req_q;
    mem_we_d       = mem_we_q;
    mem_be_d       = mem_be_q;
    mem_addr_d     = mem_addr_q;
    mem_wdata_d    = mem_wdata_q;
`ifdef RV_MEM_ARB_RR_EN
    last_owner_d   = last_owner_q;
`endif
    launch         = 1'b0;
    instr_gnt_o    = 1'b0;
    data_gnt_o     = 1'b0;
    instr_rvalid_o = 1'b0;
    data_rvalid_o  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        launch = i_elig | d_elig;
      end
      ST_ADDR: begin
        if ((owner_q == OWN_I) && instr_flush_i) drop_d = 1'b1;
        if (mem_gnt_i) begin
          instr_gnt_o = (owner_q == OWN_I) & ~i_quiet;
          data_gnt_o  = (owner_q == OWN_D);
          mem_req_d   = 1'b0;
          state_d     = ST_RESP;
        end
      end
      ST_RESP: begin
        if (mem_rvalid_i) begin
          instr_rvalid_o = (owner_q == OWN_I) & ~i_quiet;
          data_rvalid_o  = (owner_q == OWN_D);
          drop_d         = 1'b0;
          launch         = i_elig | d_elig;
          state_d        = ST_IDLE;
        end else if ((owner_q == OWN_I) && instr_flush_i) begin
          drop_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (launch) begin
      state_d     = ST_ADDR;
      mem_req_d   = 1'b1;
      owner_d     = sel_d ? OWN_D : OWN_I;
      mem_we_d    = sel_d & data_we_i;
      mem_be_d    = sel_d ? data_be_i : '1;
      mem_addr_d  = sel_d ? data_addr_i : instr_addr_i;
      mem_wdata_d = sel_d ? data_wdata_i : '0;
`ifdef RV_MEM_ARB_RR_EN
      last_owner_d = sel_d ? OWN_D : OWN_I;
`endif
    end
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_I;
      drop_q      <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      drop_q      <= drop_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

`ifdef RV_MEM_ARB_RR_EN
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) last_owner_q <= OWN_I;
    else          last_owner_q <= last_owner_d;
  end
`endif

  assign instr_rdata_o = mem_rdata_i;
  assign data_rdata_o  = mem_rdata_i;
  assign mem_req_o     = mem_req_q;
  assign mem_we_o      = mem_we_q;
  assign mem_be_o      = mem_be_q;
  assign mem_addr_o    = mem_addr_q;
  assign mem_wdata_o   = mem_wdata_q;

endmodule

// File: tb/tb_rv_mem_port_arbiter.sv
// Bench for rv_mem_port_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
module tb_rv_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        arstn;
  logic        ireq, flush, dreq, dwe;
  logic [3:0]  dbe;
  logic [31:0] iaddr, daddr, dwdata;
  logic        igrant, irv, dgrant, drv;
  logic [31:0] irdata, drdata;
  logic        mreq, mwe;
  logic [3:0]  mbe;
  logic [31:0] maddr, mwdata;
  logic        mgnt, mrv;
  logic [31:0] mrdata;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  typedef struct {
    bit          valid;
    bit          is_d;
    bit          granted;
    bit          dropped;
    bit          we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  rv_mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk_i(clk), .arstn_i(arstn),
    .instr_req_i(ireq), .instr_addr_i(iaddr), .instr_flush_i(flush),
    .instr_gnt_o(igrant), .instr_rvalid_o(irv), .instr_rdata_o(irdata),
    .data_req_i(dreq), .data_we_i(dwe), .data_be_i(dbe), .data_addr_i(daddr),
    .data_wdata_i(dwdata), .data_gnt_o(dgrant), .data_rvalid_o(drv), .data_rdata_o(drdata),
    .mem_req_o(mreq), .mem_we_o(mwe), .mem_be_o(mbe), .mem_addr_o(maddr), .mem_wdata_o(mwdata),
    .mem_gnt_i(mgnt), .mem_rvalid_i(mrv), .mem_rdata_i(mrdata)
  );

  always #5 clk = ~clk;

  task automatic next_cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    ireq = 0; flush = 0; dreq = 0; dwe = 0; dbe = '0; iaddr = '0; daddr = '0; dwdata = '0;
    mgnt = 0; mrv = 0; mrdata = '0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    arstn = 0;
    ireq = 1; dreq = 1; mgnt = 1; mrv = 1; mrdata = 32'hA5A5_0F0F;
    #1;
    vectors++; if (mreq !== 1'b0) begin miscompares++; $display("FAIL reset_mem_req: got %b want 0", mreq); end
    vectors++; if ({mwe, mbe, maddr, mwdata} !== '0) begin miscompares++; $display("FAIL reset_mem_fields: got %h want 0", {mwe, mbe, maddr, mwdata}); end
    vectors++; if ({igrant, dgrant, irv, drv} !== 4'b0) begin miscompares++; $display("FAIL reset_handshakes: got %b want 0000", {igrant, dgrant, irv, drv}); end
    vectors++; if (irdata !== 32'hA5A5_0F0F) begin miscompares++; $display("FAIL reset_rdata_pass: got %h want a5a50f0f", irdata); end
    clear_inputs();
    next_cyc();
    arstn = 1;
    next_cyc();
  endtask

  task automatic test_single_fetch();
    ireq = 1; iaddr = 32'h100;
    #1;
    vectors++; if (mreq !== 1'b0) begin miscompares++; $display("FAIL fetch_req_latency: got %b want 0", mreq); end
    next_cyc();
    vectors++; if (mreq !== 1'b1 || maddr !== 32'h100 || mwe !== 1'b0) begin miscompares++; $display("FAIL fetch_issue: got req=%b addr=%h we=%b want req=1 addr=100 we=0", mreq, maddr, mwe); end
    next_cyc();
    mgnt = 1; #1;
    vectors++; if (igrant !== 1'b1 || dgrant !== 1'b0) begin miscompares++; $display("FAIL fetch_gnt: got i=%b d=%b want i=1 d=0", igrant, dgrant); end
    next_cyc();
    mgnt = 0; ireq = 0; mrv = 1; mrdata = 32'hDEAD_BEEF; #1;
    vectors++; if (mreq !== 1'b0) begin miscompares++; $display("FAIL fetch_req_drop: got %b want 0", mreq); end
    vectors++; if (irv !== 1'b1 || irdata !== 32'hDEAD_BEEF || drv !== 1'b0) begin miscompares++; $display("FAIL fetch_resp: got rv=%b data=%h drv=%b want 1 deadbeef 0", irv, irdata, drv); end
    next_cyc();
    mrv = 0;
  endtask

  task automatic test_priority();
    ireq = 1; iaddr = 32'h300;
    dreq = 1; dwe = 1; dbe = 4'b0001; daddr = 32'h2000; dwdata = 32'h55;
    next_cyc();
    vectors++; if (mreq !== 1'b1 || mwe !== 1'b1 || maddr !== 32'h2000 || mwdata !== 32'h55 || mbe !== 4'b0001) begin
      miscompares++; $display("FAIL prio_d_first: got req=%b we=%b addr=%h wdata=%h be=%b", mreq, mwe, maddr, mwdata, mbe); end
    mgnt = 1; #1;
    vectors++; if (dgrant !== 1'b1 || igrant !== 1'b0) begin miscompares++; $display("FAIL prio_gnt: got d=%b i=%b want d=1 i=0", dgrant, igrant); end
    next_cyc();
    dreq = 0; mgnt = 0; mrv = 1; mrdata = 32'h0; #1;
    vectors++; if (drv !== 1'b1 || irv !== 1'b0) begin miscompares++; $display("FAIL prio_d_resp: got d=%b i=%b want d=1 i=0", drv, irv); end
    next_cyc();
    mrv = 0; #1;
    vectors++; if (mreq !== 1'b1 || maddr !== 32'h300 || mwe !== 1'b0) begin miscompares++; $display("FAIL prio_b2b_i: got req=%b addr=%h we=%b want 1 300 0", mreq, maddr, mwe); end
    mgnt = 1; #1;
    vectors++; if (igrant !== 1'b1) begin miscompares++; $display("FAIL prio_i_gnt: got %b want 1", igrant); end
    next_cyc();
    ireq = 0; mgnt = 0; mrv = 1; mrdata = 32'h1234_5678; #1;
    vectors++; if (irv !== 1'b1 || irdata !== 32'h1234_5678) begin miscompares++; $display("FAIL prio_i_resp: got rv=%b data=%h want 1 12345678", irv, irdata); end
    next_cyc();
    clear_inputs();
  endtask

  task automatic test_flush_resp();
    ireq = 1; iaddr = 32'h40;
    next_cyc();
    mgnt = 1; #1;
    vectors++; if (igrant !== 1'b1) begin miscompares++; $display("FAIL flush_first_gnt: got %b want 1", igrant); end
    next_cyc();
    mgnt = 0; flush = 1; iaddr = 32'h80;
    next_cyc();
    flush = 0; mrv = 1; mrdata = 32'h1111; #1;
    vectors++; if (irv !== 1'b0) begin miscompares++; $display("FAIL flush_dropped_resp: got %b want 0", irv); end
    next_cyc();
    mrv = 0; #1;
    vectors++; if (mreq !== 1'b1 || maddr !== 32'h80) begin miscompares++; $display("FAIL flush_reissue: got req=%b addr=%h want 1 80", mreq, maddr); end
    mgnt = 1; #1;
    vectors++; if (igrant !== 1'b1) begin miscompares++; $display("FAIL flush_new_gnt: got %b want 1", igrant); end
    next_cyc();
    ireq = 0; mgnt = 0; mrv = 1; mrdata = 32'h2222; #1;
    vectors++; if (irv !== 1'b1 || irdata !== 32'h2222) begin miscompares++; $display("FAIL flush_new_resp: got rv=%b data=%h want 1 2222", irv, irdata); end
    next_cyc();
    clear_inputs();
  endtask

  task automatic test_flush_with_rvalid();
    ireq = 1; iaddr = 32'h500;
    next_cyc();
    mgnt = 1;
    next_cyc();
    ireq = 0; mgnt = 0; mrv = 1; flush = 1; mrdata = 32'h3333; #1;
    vectors++; if (irv !== 1'b0) begin miscompares++; $display("FAIL coinc_flush_rvalid: got %b want 0", irv); end
    next_cyc();
    mrv = 0; flush = 0; ireq = 1; iaddr = 32'h600; #1;
    vectors++; if (mreq !== 1'b0) begin miscompares++; $display("FAIL coinc_idle: got %b want 0", mreq); end
    next_cyc();
    vectors++; if (mreq !== 1'b1 || maddr !== 32'h600) begin miscompares++; $display("FAIL coinc_from_idle: got req=%b addr=%h want 1 600", mreq, maddr); end
    mgnt = 1; #1;
    vectors++; if (igrant !== 1'b1) begin miscompares++; $display("FAIL coinc_drop_cleared: got %b want 1", igrant); end
    next_cyc();
    ireq = 0; mgnt = 0; mrv = 1;
    next_cyc();
    clear_inputs();
  endtask

  task automatic test_reset_mid_addr();
    ireq = 1; iaddr = 32'h700;
    next_cyc();
    vectors++; if (mreq !== 1'b1) begin miscompares++; $display("FAIL rst_mid_pre: got %b want 1", mreq); end
    arstn = 0; mgnt = 1; mrv = 1; #1;
    vectors++; if (mreq !== 1'b0 || {igrant, dgrant, irv, drv} !== 4'b0) begin
      miscompares++; $display("FAIL rst_mid_addr: got req=%b hs=%b want 0 0000", mreq, {igrant, dgrant, irv, drv}); end
    mgnt = 0; mrv = 0;
    next_cyc();
    arstn = 1;
    next_cyc();
    vectors++; if (mreq !== 1'b1 || maddr !== 32'h700) begin miscompares++; $display("FAIL rst_mid_resume: got req=%b addr=%h want 1 700", mreq, maddr); end
    mgnt = 1;
    next_cyc();
    ireq = 0; mgnt = 0; mrv = 1;
    next_cyc();
    clear_inputs();
  endtask

  // Transaction-level view: at most one bus transaction, which is either awaiting grant or awaiting data.
  task automatic test_random(input int unsigned n);
    txn_t        t;
    bit          last_d, e_req, accept, done, e_ig, e_dg, e_ir, e_dr, ie, de, pick_d;
    int unsigned delay;
    t = '{default: '0};
    last_d = 0; delay = 0;
    clear_inputs();
    arstn = 0;
    next_cyc();
    arstn = 1;
    for (int unsigned c = 0; c < n; c++) begin
      if (!ireq && $urandom_range(0, 2) == 0) begin ireq = 1; iaddr = $urandom & 32'hFFFF_FFFC; end
      flush = ($urandom_range(0, 9) == 0);
      if (!dreq && $urandom_range(0, 2) == 0) begin
        dreq = 1; dwe = $urandom_range(0, 1); dbe = 4'($urandom); daddr = $urandom; dwdata = $urandom;
      end
      e_req = t.valid && !t.granted;
      mgnt = e_req && ($urandom_range(0, 1) == 1);
      if (t.valid && t.granted) begin
        if (delay == 0) mrv = 1;
        else begin mrv = 0; delay--; end
      end else begin
        mrv = ($urandom_range(0, 15) == 0);
      end
      mrdata = $urandom;
      #1;
      accept = e_req && mgnt;
      done   = t.valid && t.granted && mrv;
      e_ig   = accept && !t.is_d && !t.dropped && !flush;
      e_dg   = accept && t.is_d;
      e_ir   = done && !t.is_d && !t.dropped && !flush;
      e_dr   = done && t.is_d;
      vectors++; if (mreq !== e_req) begin miscompares++; $display("FAIL rnd_mem_req c=%0d: got %b want %b", c, mreq, e_req); end
      if (e_req) begin
        vectors++; if (maddr !== t.addr || mwe !== t.we) begin miscompares++; $display("FAIL rnd_mem_addr c=%0d: got %h/%b want %h/%b", c, maddr, mwe, t.addr, t.we); end
        if (t.is_d) begin
          vectors++; if (mbe !== t.be || mwdata !== t.wdata) begin miscompares++; $display("FAIL rnd_mem_wr c=%0d: got %b/%h want %b/%h", c, mbe, mwdata, t.be, t.wdata); end
        end
      end
      vectors++; if (igrant !== e_ig) begin miscompares++; $display("FAIL rnd_instr_gnt c=%0d: got %b want %b", c, igrant, e_ig); end
      vectors++; if (dgrant !== e_dg) begin miscompares++; $display("FAIL rnd_data_gnt c=%0d: got %b want %b", c, dgrant, e_dg); end
      vectors++; if (irv !== e_ir) begin miscompares++; $display("FAIL rnd_instr_rvalid c=%0d: got %b want %b", c, irv, e_ir); end
      vectors++; if (drv !== e_dr) begin miscompares++; $display("FAIL rnd_data_rvalid c=%0d: got %b want %b", c, drv, e_dr); end
      if (e_ir) begin
        vectors++; if (irdata !== mrdata) begin miscompares++; $display("FAIL rnd_instr_rdata c=%0d: got %h want %h", c, irdata, mrdata); end
      end
      if (e_dr) begin
        vectors++; if (drdata !== mrdata) begin miscompares++; $display("FAIL rnd_data_rdata c=%0d: got %h want %h", c, drdata, mrdata); end
      end
      ie = ireq && !flush;
      de = dreq;
      if (!t.valid || done) begin
        if (ie || de) begin
`ifdef RV_MEM_ARB_RR_EN
          pick_d = (ie && de) ? !last_d : de;
`else
          pick_d = de;
`endif
          t.valid = 1; t.is_d = pick_d; t.granted = 0; t.dropped = 0;
          t.we    = pick_d ? dwe : 1'b0;
          t.be    = pick_d ? dbe : 4'hF;
          t.addr  = pick_d ? daddr : iaddr;
          t.wdata = pick_d ? dwdata : 32'h0;
          last_d  = pick_d;
        end else begin
          t.valid = 0;
        end
      end else begin
        if (accept) begin t.granted = 1; delay = $urandom_range(0, 2); end
        if (flush && !t.is_d) t.dropped = 1;
      end
      if (e_ig || flush) ireq = 0;
      if (e_dg) dreq = 0;
      next_cyc();
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    arstn = 0;
    test_reset();
    test_single_fetch();
    test_priority();
    test_flush_resp();
    test_flush_with_rvalid();
    test_reset_mid_addr();
    test_random(4000);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
